// File: rtl/shift_unit_seq_pkg.sv
// Shared CPU definitions used by the iterative shifter: ALU op codes, data width
// and the shifter FSM state encoding.
package shift_unit_seq_pkg;

  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam int WIDTH = 16;
  localparam int SHW   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_unit_seq.sv
// One-bit-per-clock SLL/SRA shifter for the ALU result mux.
// Start/Busy/Done handshake lets control stall while a shift is in flight.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for Start; results hold the last computed values
//   ST_SHIFT | shifting one bit per edge; count holds edges still to go
//   ST_DONE  | one-cycle result-valid pulse; a new Start is accepted here
module shift_unit_seq
  import shift_unit_seq_pkg::*;
#(
  parameter int WIDTH = shift_unit_seq_pkg::WIDTH,
  parameter int SHW   = shift_unit_seq_pkg::SHW
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   ShAmt,
  output logic [WIDTH-1:0] SLL_Out,
  output logic [WIDTH-1:0] SRA_Out,
  output logic             Busy,
  output logic             Done
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sll_q, sll_nxt;
  logic [WIDTH-1:0] sra_q, sra_nxt;
  logic [SHW-1:0]   count_q, count_nxt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_IDLE;
      sll_q   <= '0;
      sra_q   <= '0;
      count_q <= '0;
    end else begin
      state   <= state_nxt;
      sll_q   <= sll_nxt;
      sra_q   <= sra_nxt;
      count_q <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sll_nxt   = sll_q;
    sra_nxt   = sra_q;
    count_nxt = count_q;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          sll_nxt   = A;
          sra_nxt   = A;
          count_nxt = ShAmt;
          state_nxt = (ShAmt == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sll_nxt   = {sll_q[WIDTH-2:0], 1'b0};
        sra_nxt   = {sra_q[WIDTH-1], sra_q[WIDTH-1:1]};
        count_nxt = count_q - 1'b1;
        // Leaving at count==1 means count is never decremented past zero.
        if (count_q == SHW'(1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign SLL_Out = sll_q;
  assign SRA_Out = sra_q;
  assign Busy    = (state == ST_SHIFT);
  assign Done    = (state == ST_DONE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: the driver queues hand-computed results,
// a monitor pops and compares them whenever Done is seen.
module tb_shift_unit_seq;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] A;
  logic [3:0]  ShAmt;
  logic [15:0] SLL_Out;
  logic [15:0] SRA_Out;
  logic        Busy;
  logic        Done;

  typedef struct {
    logic [15:0] sll;
    logic [15:0] sra;
    int          busy;
  } exp_t;

  exp_t exp_q[$];
  int   tests    = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   exp_cnt  = 0;
  int   busy_cnt = 0;

  shift_unit_seq dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .A      (A),
    .ShAmt  (ShAmt),
    .SLL_Out(SLL_Out),
    .SRA_Out(SRA_Out),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares results and the number of Busy cycles of each transaction.
  always @(negedge Clock) begin
    if (Done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done_cnt), 32'(exp_cnt));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sll_out", 32'(SLL_Out), 32'(e.sll));
        check("sra_out", 32'(SRA_Out), 32'(e.sra));
        check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
      end
      busy_cnt = 0;
    end else if (Busy) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  // Issue one request, then wait for Done and check its latency in edges.
  // inject >= 0 pulses a conflicting Start that many edges into the shift.
  task automatic issue(input logic [15:0] a, input logic [3:0] sh,
                       input logic [15:0] es, input logic [15:0] er, input int inject);
    bit got;
    A     = a;
    ShAmt = sh;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    exp_q.push_back('{sll: es, sra: er, busy: int'(sh)});
    exp_cnt++;
    A     = 16'hDEAD;
    ShAmt = 4'h5;
    got   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (Done) begin
        check("done_latency", 32'(k), 32'(sh));
        got = 1'b1;
        break;
      end
      Start = (k == inject);
      if (k == inject) begin
        A     = 16'hFFFF;
        ShAmt = 4'd3;
      end
      @(posedge Clock);
    end
    Start = 1'b0;
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_check(input logic [15:0] es, input logic [15:0] er);
    @(posedge Clock);
    #1;
    @(negedge Clock);
    check("done_single_pulse", 32'(Done), 32'd0);
    check("idle_not_busy", 32'(Busy), 32'd0);
    check("hold_sll", 32'(SLL_Out), 32'(es));
    check("hold_sra", 32'(SRA_Out), 32'(er));
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    A     = '0;
    ShAmt = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_sll", 32'(SLL_Out), 32'd0);
    check("reset_sra", 32'(SRA_Out), 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    Reset = 1'b0;
    @(posedge Clock);
    #1;

    issue(16'h8001, 4'd1, 16'h0002, 16'hC000, -1);
    @(posedge Clock); #1;
    issue(16'h1234, 4'd0, 16'h1234, 16'h1234, -1);
    @(posedge Clock); #1;
    issue(16'h8000, 4'd15, 16'h0000, 16'hFFFF, -1);
    idle_check(16'h0000, 16'hFFFF);
    #1;
    issue(16'h7F00, 4'd4, 16'hF000, 16'h07F0, -1);
    @(posedge Clock); #1;
    issue(16'hC3A5, 4'd8, 16'hA500, 16'hFFC3, 2);
    idle_check(16'hA500, 16'hFFC3);

    // Abort a shift with reset in its third SHIFT cycle.
    #1;
    A     = 16'h5555;
    ShAmt = 4'd8;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("busy_before_abort", 32'(Busy), 32'd1);
    Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    check("abort_sll", 32'(SLL_Out), 32'd0);
    check("abort_sra", 32'(SRA_Out), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;
    issue(16'h0003, 4'd2, 16'h000C, 16'h0000, -1);

    @(posedge Clock); #1;
    issue(16'h00FF, 4'd1, 16'h01FE, 16'h007F, -1);
    issue(16'hF0F0, 4'd1, 16'hE1E0, 16'hF878, -1);

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_pulse_count", 32'(done_cnt), 32'(exp_cnt));
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Iterative shifter for the 16-bit CPU ALU.
- Produces the SLL and SRA results that the ALU output select stage routes to the result bus for ALU ops 110 (SLL) and 111 (SRA).
- Shifts one bit per clock, so a full barrel shifter is not needed.
- Uses a Start/Busy/Done handshake, so control can stall the pipeline while a shift is in progress.

Parameters:
- WIDTH, 16, data width of operand and results.
- SHW, 4, shift-amount width; the maximum shift is 2^SHW-1 = 15.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a shift; sampled only when the unit is idle (IDLE or DONE).
- A  input  WIDTH  operand to shift.
- ShAmt  input  SHW  shift amount, unsigned.
- SLL_Out  output  WIDTH  logical-left result; drives the mux SLL input.
- SRA_Out  output  WIDTH  arithmetic-right result; drives the mux SRA input.
- Busy  output  1  high while shifting; control stalls on this.
- Done  output  1  one-cycle pulse when SLL_Out and SRA_Out are valid.

Behaviour:
- Clocking: one clock, Clock. Reset is synchronous and active-high. All state changes on the rising edge of Clock.
- Reset (dominates every other input, including mid-shift):
  - state goes to IDLE;
  - SLL_Out=0, SRA_Out=0, count=0;
  - Busy=0, Done=0.
- States: IDLE, SHIFT, DONE. The state is held in a registered encoding.
- Busy = (state==SHIFT). Done = (state==DONE). Both decode directly from the state register; there is no combinational path from inputs.
- IDLE or DONE, Start=1 at an edge:
  - Load SLL_Out<=A, SRA_Out<=A, count<=ShAmt.
  - If ShAmt==0, next state is DONE. Otherwise next state is SHIFT.
- IDLE or DONE, Start=0:
  - Next state is IDLE.
  - Result registers hold their value.
- SHIFT, each edge:
  - SLL_Out <= {SLL_Out[WIDTH-2:0],1'b0}.
  - SRA_Out <= {SRA_Out[WIDTH-1],SRA_Out[WIDTH-1:1]}, i.e. sign-replicating.
  - count <= count-1.
  - If count==1, next state is DONE. Otherwise stay in SHIFT.
- Latency: Done is high in the cycle following the Nth edge after the accepting edge, where N=ShAmt. For ShAmt=0, Done is high in the cycle right after the accepting edge.
  - Total from request to result: N+1 edges.
  - Throughput: back-to-back requests are allowed because Start is accepted in the DONE cycle.
- Start while in SHIFT is ignored. A, ShAmt and Start changing during SHIFT have no effect.
- Results hold after Done until the next accepted Start. The downstream mux may sample them any time Busy=0.
- count is SHW bits wide. It never wraps, because SHIFT exits at count==1.
- ShAmt=15 is the boundary case:
  - SLL_Out ends at 0.
  - SRA_Out ends at all copies of the sign bit (0x0000 or 0xFFFF).
- No X propagation: every register has a reset value.

Decomposition:
- Shared CPU package holds:
  - ALU op encodings: OP_SLL=3'b110, OP_SRA=3'b111;
  - WIDTH=16;
  - state encoding constants ST_IDLE, ST_SHIFT, ST_DONE.
- No sub-module is needed; a single module holds the FSM, the counter and the two shift registers.
- The op decode that generates Start (ALUOp is OP_SLL or OP_SRA) lives in the control unit, not here.

Test Plan:
- A=0x8001, ShAmt=1, Start pulse → Done after 1 edge following acceptance; SLL_Out=0x0002, SRA_Out=0xC000; Busy high for exactly 1 cycle.
- A=0x1234, ShAmt=0 → Done in the cycle right after acceptance; Busy never high; SLL_Out=SRA_Out=0x1234.
- A=0x8000, ShAmt=15 → Busy high for 15 cycles; then SLL_Out=0x0000, SRA_Out=0xFFFF, Done for 1 cycle. Repeat with A=0x7F00, ShAmt=4 → SLL_Out=0xF000, SRA_Out=0x07F0.
- Start pulse with A=0xFFFF, ShAmt=3 applied mid-SHIFT of a previous ShAmt=8 request → ignored; results match the first request only; Done pulses once.
- Reset asserted on the 3rd SHIFT cycle → next cycle all outputs are 0 and state is IDLE; a following Start with A=0x0003, ShAmt=2 completes normally (SLL=0x000C, SRA=0x0000).
- Start held high in the DONE cycle with a new A=0xF0F0, ShAmt=1 → accepted back-to-back; Done pulses again after 1 edge; SLL=0xE1E0, SRA=0xF878.
